// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one MemSplit32-style slave port between N masters.
// In-order read responses are routed back to their issuer through a small ID FIFO.
`timescale 1ns/1ps
module mem_rr_arbiter #(
    parameter int N_MASTERS  = 5,
    parameter int RESP_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  logic [N_MASTERS-1:0]              m_req_i,
    input  logic [N_MASTERS-1:0]              m_we_i,
    input  logic [32*N_MASTERS-1:0]           m_addr_bi,
    input  logic [4*N_MASTERS-1:0]            m_be_bi,
    input  logic [32*N_MASTERS-1:0]           m_wdata_bi,
    output logic [N_MASTERS-1:0]              m_ack_o,
    output logic [N_MASTERS-1:0]              m_resp_o,
    output logic [32*N_MASTERS-1:0]           m_rdata_bo,
    output logic                              s_req_o,
    output logic                              s_we_o,
    output logic [31:0]                       s_addr_bo,
    output logic [3:0]                        s_be_bo,
    output logic [31:0]                       s_wdata_bo,
    input  logic                              s_ack_i,
    input  logic                              s_resp_i,
    input  logic [31:0]                       s_rdata_bi,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   rd_pending_o,
    output logic                              resp_err_o
);

    localparam int ID_W  = $clog2(N_MASTERS);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH+1);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  locked_id_q, locked_id_d;
    logic             lock_q, lock_d;
    logic             resp_err_q;
    logic [ID_W-1:0]  id_mem_q [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic [ID_W-1:0]  winner, head_id;
    logic             win_vld, sel_we;
    logic [31:0]      sel_addr, sel_wdata;
    logic [3:0]       sel_be;
    logic             fifo_full, fifo_empty, s_req_int, accept, push, pop;

    // Round-robin scan from rr_ptr; an open lock pins the grant to the stalled master.
    always_comb begin
        logic [ID_W:0] idx;
        logic          found;
        winner = rr_ptr_q;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_MASTERS)) idx = idx - (ID_W+1)'(N_MASTERS);
            if (!found && m_req_i[idx[ID_W-1:0]]) begin
                winner = idx[ID_W-1:0];
                found  = 1'b1;
            end
        end
        if (lock_q) winner = locked_id_q;
    end

    always_comb begin
        win_vld   = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (winner == ID_W'(k) && m_req_i[k]) begin
                win_vld   = 1'b1;
                sel_we    = m_we_i[k];
                sel_addr  = m_addr_bi[32*k +: 32];
                sel_be    = m_be_bi[4*k +: 4];
                sel_wdata = m_wdata_bi[32*k +: 32];
            end
        end
    end

    assign fifo_full  = (count_q == CNT_W'(RESP_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign s_req_int  = win_vld & ~fifo_full;
    assign accept     = s_req_int & s_ack_i;
    assign push       = accept & ~sel_we;
    assign pop        = s_resp_i & ~fifo_empty;
    assign head_id    = id_mem_q[rd_ptr_q];

    // Combinational outputs are forced low while reset is asserted.
    assign s_req_o      = s_req_int & ~arst_i;
    assign s_we_o       = sel_we & ~arst_i;
    assign s_addr_bo    = arst_i ? '0 : sel_addr;
    assign s_be_bo      = arst_i ? '0 : sel_be;
    assign s_wdata_bo   = arst_i ? '0 : sel_wdata;
    assign rd_pending_o = count_q;
    assign resp_err_o   = resp_err_q;

    always_comb begin
        m_ack_o    = '0;
        m_resp_o   = '0;
        m_rdata_bo = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (winner == ID_W'(k)) m_ack_o[k] = accept & ~arst_i;
            if (pop && !arst_i && head_id == ID_W'(k)) begin
                m_resp_o[k]             = 1'b1;
                m_rdata_bo[32*k +: 32]  = s_rdata_bi;
            end
        end
    end

    always_comb begin
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (lock_q && !m_req_i[locked_id_q]) begin
            lock_d = 1'b0;
        end else if (accept) begin
            lock_d = 1'b0;
        end else if (s_req_int && !s_ack_i) begin
            lock_d      = 1'b1;
            locked_id_d = winner;
        end
        if (accept) rr_ptr_d = (winner == ID_W'(N_MASTERS-1)) ? '0 : winner + ID_W'(1);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
            count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
            resp_err_q  <= resp_err_q | (s_resp_i & fifo_empty);
        end
    end

    // ID storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push) id_mem_q[wr_ptr_q] <= winner;
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: read responses and write grant order are
// predicted into scoreboard queues and compared when the DUT produces them.
`timescale 1ns/1ps
module tb_mem_rr_arbiter;
    localparam int N  = 5;
    localparam int D  = 4;
    localparam int CW = $clog2(D+1);

    logic            clk = 1'b0;
    logic            arst;
    logic [N-1:0]    m_req, m_we, m_ack, m_resp;
    logic [32*N-1:0] m_addr, m_wdata, m_rdata;
    logic [4*N-1:0]  m_be;
    logic            s_req, s_we, s_ack, s_resp, resp_err;
    logic [31:0]     s_addr, s_wdata, s_rdata;
    logic [3:0]      s_be;
    logic [CW-1:0]   rd_pending;

    typedef struct { int id; logic [31:0] data; } rsp_t;
    rsp_t sb[$];
    int   ack_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cnt [N];
    int   e;

    mem_rr_arbiter #(.N_MASTERS(N), .RESP_DEPTH(D)) dut (
        .clk_i(clk), .arst_i(arst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_bi(m_addr), .m_be_bi(m_be),
        .m_wdata_bi(m_wdata), .m_ack_o(m_ack), .m_resp_o(m_resp), .m_rdata_bo(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be),
        .s_wdata_bo(s_wdata), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
        .rd_pending_o(rd_pending), .resp_err_o(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        m_req[k]            = req;
        m_we[k]             = we;
        m_addr[32*k +: 32]  = addr;
        m_wdata[32*k +: 32] = wdata;
        m_be[4*k +: 4]      = 4'hF;
    endtask

    task automatic idle();
        m_req = '0; m_we = '0; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic exp_rd(input int id, input logic [31:0] d);
        rsp_t r;
        r.id = id; r.data = d;
        sb.push_back(r);
    endtask

    // Slave model returns the data planned for the oldest outstanding read.
    task automatic slave_resp();
        s_resp  = 1'b1;
        s_rdata = (sb.size() > 0) ? sb[0].data : 32'h0;
    endtask

    task automatic check_resp(input string tag);
        rsp_t          r;
        logic [159:0]  v;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s: observed=response expected=empty scoreboard", tag);
            return;
        end
        r = sb.pop_front();
        v = '0;
        v[32*r.id +: 32] = r.data;
        chk({tag, "_strobe"}, 160'(m_resp), 160'(1) << r.id);
        chk({tag, "_data"}, m_rdata, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        drive(0, 1, 1, 32'h40, 32'h1); s_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sreq", s_req, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_pend", rd_pending, 0);
        chk("rst_err", resp_err, 0);
        tick(); arst = 1'b0; idle();

        // single write from m2
        drive(2, 1, 1, 32'h100, 32'hDEADBEEF); s_ack = 1'b1;
        smp();
        chk("t1_sreq", s_req, 1);
        chk("t1_we", s_we, 1);
        chk("t1_addr", s_addr, 32'h100);
        chk("t1_be", s_be, 4'hF);
        chk("t1_wdata", s_wdata, 32'hDEADBEEF);
        chk("t1_ack", m_ack, 5'b00100);
        tick(); m_req = '0;
        smp();
        chk("t1_pend", rd_pending, 0);
        chk("t1_idle_sreq", s_req, 0);
        tick();
        drive(0, 1, 1, 32'h200, 32'h0); drive(3, 1, 1, 32'h300, 32'h3);
        smp(); chk("t1_ptr3", m_ack, 5'b01000);
        tick(); m_req[3] = 1'b0;
        smp(); chk("t1_next_m0", m_ack, 5'b00001);
        tick(); idle();
        drive(4, 1, 1, 32'h400, 32'h4); s_ack = 1'b1;
        smp(); chk("t2_prep", m_ack, 5'b10000);
        tick(); idle();

        // all masters writing continuously
        for (int k = 0; k < N; k++) begin
            drive(k, 1, 1, 32'h1000 + 32'(k*4), 32'(k));
            cnt[k] = 0;
        end
        s_ack = 1'b1;
        ack_q = '{0, 1, 2, 3, 4, 0, 1};
        for (int c = 0; c < 7; c++) begin
            smp();
            e = ack_q.pop_front();
            chk("t2_ack", m_ack, 160'(1) << e);
            chk("t2_addr", s_addr, 32'h1000 + 32'(e*4));
            if (c < 5) for (int k = 0; k < N; k++) cnt[k] += int'(m_ack[k]);
            tick();
        end
        for (int k = 0; k < N; k++) chk("t2_once", cnt[k], 1);
        idle();
        drive(0, 1, 1, 32'h500, 32'h0); s_ack = 1'b1;
        smp(); chk("t3_prep", m_ack, 5'b00001);
        tick(); idle();

        // m1 stalled by slave, m3 waits
        drive(1, 1, 1, 32'h110, 32'h11); drive(3, 1, 1, 32'h330, 32'h33);
        for (int c = 0; c < 4; c++) begin
            s_ack = (c == 3);
            smp();
            chk("t3_addr", s_addr, 32'h110);
            chk("t3_ack", m_ack, (c == 3) ? 5'b00010 : 5'b00000);
            tick();
        end
        m_req[1] = 1'b0;
        smp(); chk("t3_next", m_ack, 5'b01000);
        tick(); idle();

        // lock holds grant against a master nearer the pointer
        drive(1, 1, 1, 32'h120, 32'h0);
        smp(); chk("lk_addr", s_addr, 32'h120);
        tick(); drive(0, 1, 1, 32'h020, 32'h0);
        smp(); chk("lk_hold_addr", s_addr, 32'h120);
        tick(); s_ack = 1'b1;
        smp(); chk("lk_ack", m_ack, 5'b00010);
        tick(); m_req[1] = 1'b0;
        smp(); chk("lk_m0", m_ack, 5'b00001);
        tick(); idle();

        // locked master drops request
        drive(2, 1, 1, 32'h220, 32'h0);
        smp(); chk("viol_sreq", s_req, 1);
        tick(); m_req[2] = 1'b0; drive(3, 1, 1, 32'h330, 32'h0);
        smp(); chk("viol_drop_sreq", s_req, 0);
        tick();
        smp(); chk("viol_m3_sreq", s_req, 1); chk("viol_m3_addr", s_addr, 32'h330);
        tick(); s_ack = 1'b1;
        smp(); chk("viol_m3_ack", m_ack, 5'b01000);
        tick(); idle();

        // two reads, responses routed in order
        drive(0, 1, 0, 32'hA0, 32'h0); s_ack = 1'b1;
        smp(); chk("t4_ack0", m_ack, 5'b00001); exp_rd(0, 32'hA);
        tick(); m_req[0] = 1'b0; drive(4, 1, 0, 32'hB0, 32'h0);
        smp(); chk("t4_ack4", m_ack, 5'b10000); exp_rd(4, 32'hB);
        tick(); idle();
        smp(); chk("t4_pend2", rd_pending, 2);
        tick(); slave_resp();
        smp(); check_resp("t4_r0");
        tick(); s_resp = 1'b0;
        smp(); chk("t4_pend1", rd_pending, 1);
        tick(); slave_resp();
        smp(); check_resp("t4_r1");
        tick(); s_resp = 1'b0;
        smp(); chk("t4_pend0", rd_pending, 0);
        tick();

        // fill the ID FIFO, then a write must stall until one response drains
        drive(1, 1, 0, 32'h1100, 32'h0); s_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp(); chk("t5_rd_ack", m_ack, 5'b00010); exp_rd(1, 32'h11 + 32'(i));
            tick();
        end
        m_req[1] = 1'b0; drive(2, 1, 1, 32'h2200, 32'h55);
        smp();
        chk("t5_pend4", rd_pending, 4);
        chk("t5_stall_sreq", s_req, 0);
        chk("t5_stall_ack", m_ack, 0);
        tick(); slave_resp();
        smp(); check_resp("t5_r0"); chk("t5_still_stall", s_req, 0);
        tick(); s_resp = 1'b0;
        smp();
        chk("t5_fwd_sreq", s_req, 1);
        chk("t5_fwd_ack", m_ack, 5'b00100);
        chk("t5_fwd_addr", s_addr, 32'h2200);
        tick(); m_req[2] = 1'b0;
        repeat (3) begin
            slave_resp();
            smp(); check_resp("t5_drain");
            tick(); s_resp = 1'b0;
        end
        idle();
        smp(); chk("t5_pend0", rd_pending, 0);
        tick();

        // spurious response, then reset with a lock open
        s_resp = 1'b1; s_rdata = 32'hBAD;
        smp(); chk("t6_noresp", m_resp, 0); chk("t6_nordata", m_rdata, 0);
        tick(); s_resp = 1'b0;
        smp(); chk("t6_err", resp_err, 1);
        tick();
        smp(); chk("t6_err_sticky", resp_err, 1);
        tick(); drive(0, 1, 0, 32'h600, 32'h0); s_ack = 1'b1;
        smp(); chk("t6_acc", m_ack, 5'b00001);
        tick(); s_ack = 1'b0;
        smp(); chk("t6_lock_sreq", s_req, 1); chk("t6_pend1", rd_pending, 1);
        tick();
        #1 arst = 1'b1; s_resp = 1'b1; s_rdata = 32'h7;
        #1;
        chk("rst2_sreq", s_req, 0);
        chk("rst2_ack", m_ack, 0);
        chk("rst2_addr", s_addr, 0);
        chk("rst2_pend", rd_pending, 0);
        chk("rst2_err", resp_err, 0);
        chk("rst2_resp", m_resp, 0);
        chk("rst2_rdata", m_rdata, 0);
        tick(); arst = 1'b0; idle();
        drive(0, 1, 1, 32'h700, 32'h0); drive(4, 1, 1, 32'h740, 32'h0); s_ack = 1'b1;
        smp();
        chk("post_err", resp_err, 0);
        chk("post_pend", rd_pending, 0);
        chk("post_ack0", m_ack, 5'b00001);
        tick(); m_req[0] = 1'b0;
        smp(); chk("post_ack4", m_ack, 5'b10000);
        tick(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one MemSplit32-style slave port between N bus masters (CPU tiles, UART debug master) with round-robin arbitration.
- Routes in-order read responses back to the issuing master via an internal ID FIFO.
- Sits between xbar master ports and a single shared slave (e.g. a shared memory or GPIO), replacing fixed-priority sharing.

Parameters:
- N_MASTERS, 5, number of requesting masters (2..8).
- RESP_DEPTH, 4, max outstanding reads (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset.
- m_req_i  in  N_MASTERS  per-master request.
- m_we_i  in  N_MASTERS  per-master write enable.
- m_addr_bi  in  32*N_MASTERS  per-master address, master k at [32k+31:32k].
- m_be_bi  in  4*N_MASTERS  per-master byte enables.
- m_wdata_bi  in  32*N_MASTERS  per-master write data.
- m_ack_o  out  N_MASTERS  per-master command accept.
- m_resp_o  out  N_MASTERS  per-master read response strobe.
- m_rdata_bo  out  32*N_MASTERS  per-master read data.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_bo  out  32  slave address.
- s_be_bo  out  4  slave byte enables.
- s_wdata_bo  out  32  slave write data.
- s_ack_i  in  1  slave command accept.
- s_resp_i  in  1  slave read response strobe.
- s_rdata_bi  in  32  slave read data.
- rd_pending_o  out  $clog2(RESP_DEPTH+1)  outstanding read count.
- resp_err_o  out  1  sticky spurious-response flag.

Behaviour:
- Clock and reset: one clock, clk_i; reset arst_i is asynchronous, active-high.
- Reset state: rr_ptr=0, lock=0, locked_id=0, FIFO empty, resp_err_o=0. All outputs read 0 while arst_i is high.
- Handshake: a command transfers in the cycle where s_req_o=1 and s_ack_i=1 (accept). A master holds req and its fields stable until it sees its ack. Writes produce no response. Each read produces exactly one s_resp_i pulse, in command order.
- Grant, unlocked: winner is the first k with m_req_i[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N_MASTERS. Purely combinational, zero-cycle latency.
- Grant, locked: winner = locked_id.
- Forwarding: s_req_o = m_req_i[winner] & ~fifo_full. s_we_o, s_addr_bo, s_be_bo and s_wdata_bo carry the winner's fields. When no winner, all are 0.
- Ack routing: m_ack_o[winner] = s_ack_i & s_req_o. All other m_ack_o bits are 0.
- Lock:
  - Set lock=1, locked_id=winner when s_req_o=1 and s_ack_i=0.
  - Clear lock on accept.
  - Also clear lock if m_req_i[locked_id] drops (protocol violation); s_req_o=0 in that cycle.
  - Grant never moves mid-handshake.
- Pointer: on accept, rr_ptr <= (winner+1) mod N_MASTERS. Otherwise rr_ptr holds.
- ID FIFO:
  - Depth RESP_DEPTH, entries $clog2(N_MASTERS) bits.
  - Push winner id on accept with s_we_o=0.
  - Pop on s_resp_i=1 while non-empty.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo RESP_DEPTH.
  - rd_pending_o = count.
- Full stall: when count==RESP_DEPTH, s_req_o=0 for all requests, writes included. No ack is issued. Lock state is held.
- Response routing (combinational):
  - On s_resp_i with FIFO non-empty, m_resp_o[head]=1 and the head's m_rdata_bo slice = s_rdata_bi.
  - All other slices and all other cycles: rdata=0.
- Spurious response: s_resp_i with FIFO empty is dropped. No m_resp_o bit asserts. resp_err_o <= 1 and stays set until reset.
- Mid-operation reset: asserting arst_i discards outstanding IDs and any lock. Subsequent responses from the slave are the integrator's responsibility.

Test Plan:
1. Only m2 requests write addr=0x100, be=0xF, wdata=0xDEADBEEF, s_ack_i=1 -> same cycle s_addr_bo=0x100, s_wdata_bo=0xDEADBEEF, m_ack_o=5'b00100; rd_pending_o stays 0; rr_ptr becomes 3.
2. All 5 masters request writes continuously, s_ack_i=1 -> accepted order 0,1,2,3,4,0,1; each master acked exactly once per 5 cycles.
3. m1 and m3 request, s_ack_i held 0 for 3 cycles then 1 -> s_addr_bo shows m1's address all 4 cycles; m_ack_o=5'b00010 on cycle 4; next grant goes to m3.
4. m0 read then m4 read accepted; slave returns resp with 0x0000000A then 0x0000000B -> m_resp_o=5'b00001 with m0 rdata=0xA, then m_resp_o=5'b10000 with m4 rdata=0xB; rd_pending_o goes 2,1,0.
5. RESP_DEPTH=4: four reads accepted with no resp -> rd_pending_o=4, s_req_o=0 despite a pending write. One s_resp_i -> next cycle the write is forwarded and acked.
6. s_resp_i with FIFO empty -> no m_resp_o; resp_err_o=1 and stays 1. Then arst_i pulsed with m0 locked -> all outputs 0 immediately; resp_err_o=0 and rr_ptr=0 after release.
